// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
//
// Walks the network through every layer (1..NUM_LAYERS) and, inside each layer,
// through every partition (0..pcnt-1).  For each (layer, partition) pair it
// issues one dis_en pulse to the distributor with stable layer_index, p_index
// and need_act, then waits for dis_all_done before moving on.  A per-pass
// watchdog abandons a pass that never completes and raises a sticky error.
//
// Ports
//   l_clk         in   single rising-edge clock
//   rst           in   asynchronous active-high reset
//   start         in   run request, only looked at while idle
//   abort         in   synchronous abort, returns to idle from any state
//   act_mask      in   per-layer activation flags (bit i -> layer i+1), latched at start
//   p_count       in   partitions per layer, latched at start (0 behaves as 1)
//   dis_all_done  in   distributor has finished the current pass
//   dis_en        out  one-cycle pass-start pulse
//   layer_index   out  current layer, 1-based, 0 while idle
//   p_index       out  current partition, 0-based
//   need_act      out  activation flag of the current layer
//   busy          out  high whenever a run is in progress
//   done          out  one-cycle pulse on normal run completion
//   timeout_err   out  sticky watchdog flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module layer_sequencer #(
   parameter int NUM_LAYERS = 4,
   parameter int TIMEOUT    = 1024,
   parameter int TO_W       = 11
) (
   input  logic                  l_clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [NUM_LAYERS-1:0] act_mask,
   input  logic [3:0]            p_count,
   input  logic                  dis_all_done,
   output logic                  dis_en,
   output logic [3:0]            layer_index,
   output logic [3:0]            p_index,
   output logic                  need_act,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout_err
);

   // FSM encoding
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ISSUE  = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_FINISH = 2'd3;

   localparam logic [3:0]      LAST_LAYER = 4'(NUM_LAYERS);
   localparam logic [TO_W-1:0] WD_LAST    = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0] WD_ZERO    = TO_W'(0);
   localparam logic [TO_W-1:0] WD_ONE     = TO_W'(1);

   // A partition count of zero still means one pass per layer.
   function automatic logic [3:0] clamp_pcount(input logic [3:0] cnt);
      if (cnt == 4'd0) begin
         return 4'd1;
      end else begin
         return cnt;
      end
   endfunction

   // Activation flag for a 1-based layer number; caller guarantees layer_num >= 1.
   function automatic logic mask_bit(input logic [15:0] mask, input logic [3:0] layer_num);
      return mask[layer_num - 4'd1];
   endfunction

   logic [1:0]      state_r;
   logic [15:0]     mask_r;     // zero-extended copy of act_mask taken at start
   logic [3:0]      pcnt_r;     // clamped partition count taken at start
   logic [TO_W-1:0] wd_r;       // cycles spent in WAIT for the current pass

   logic [1:0]      state_nxt_s;
   logic [15:0]     mask_nxt_s;
   logic [3:0]      pcnt_nxt_s;
   logic [TO_W-1:0] wd_nxt_s;
   logic [3:0]      layer_nxt_s;
   logic [3:0]      pidx_nxt_s;
   logic            need_nxt_s;
   logic            terr_nxt_s;

   // Next-state and next-output decode; the output flops below simply capture it.
   always_comb begin
      state_nxt_s = state_r;
      mask_nxt_s  = mask_r;
      pcnt_nxt_s  = pcnt_r;
      wd_nxt_s    = wd_r;
      layer_nxt_s = layer_index;
      pidx_nxt_s  = p_index;
      need_nxt_s  = need_act;
      terr_nxt_s  = timeout_err;

      if (abort) begin
         // Abort overrides everything, including a start seen in IDLE.
         state_nxt_s = ST_IDLE;
         layer_nxt_s = 4'd0;
         pidx_nxt_s  = 4'd0;
         need_nxt_s  = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  mask_nxt_s  = 16'(act_mask);
                  pcnt_nxt_s  = clamp_pcount(p_count);
                  layer_nxt_s = 4'd1;
                  pidx_nxt_s  = 4'd0;
                  need_nxt_s  = act_mask[0];
                  terr_nxt_s  = 1'b0;
                  state_nxt_s = ST_ISSUE;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end

            ST_ISSUE: begin
               // dis_all_done is deliberately ignored here; the pass has only
               // just been launched.
               wd_nxt_s    = WD_ZERO;
               state_nxt_s = ST_WAIT;
            end

            ST_WAIT: begin
               // Completion is checked before the watchdog so that a done on
               // the deadline cycle still counts as a normal completion.
               if (dis_all_done) begin
                  if (p_index < (pcnt_r - 4'd1)) begin
                     pidx_nxt_s  = p_index + 4'd1;
                     state_nxt_s = ST_ISSUE;
                  end else if (layer_index < LAST_LAYER) begin
                     layer_nxt_s = layer_index + 4'd1;
                     pidx_nxt_s  = 4'd0;
                     need_nxt_s  = mask_bit(mask_r, layer_index + 4'd1);
                     state_nxt_s = ST_ISSUE;
                  end else begin
                     state_nxt_s = ST_FINISH;
                  end
               end else if (wd_r == WD_LAST) begin
                  terr_nxt_s  = 1'b1;
                  layer_nxt_s = 4'd0;
                  pidx_nxt_s  = 4'd0;
                  need_nxt_s  = 1'b0;
                  state_nxt_s = ST_IDLE;
               end else begin
                  wd_nxt_s = wd_r + WD_ONE;
               end
            end

            ST_FINISH: begin
               layer_nxt_s = 4'd0;
               pidx_nxt_s  = 4'd0;
               need_nxt_s  = 1'b0;
               state_nxt_s = ST_IDLE;
            end

            default: begin
               layer_nxt_s = 4'd0;
               pidx_nxt_s  = 4'd0;
               need_nxt_s  = 1'b0;
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // State, latched run parameters, watchdog and all registered outputs.
   always_ff @(posedge l_clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         mask_r      <= 16'd0;
         pcnt_r      <= 4'd1;
         wd_r        <= WD_ZERO;
         dis_en      <= 1'b0;
         layer_index <= 4'd0;
         p_index     <= 4'd0;
         need_act    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         mask_r      <= mask_nxt_s;
         pcnt_r      <= pcnt_nxt_s;
         wd_r        <= wd_nxt_s;
         layer_index <= layer_nxt_s;
         p_index     <= pidx_nxt_s;
         need_act    <= need_nxt_s;
         timeout_err <= terr_nxt_s;
         // Moore outputs are registered copies of the state being entered.
         dis_en      <= (state_nxt_s == ST_ISSUE);
         busy        <= (state_nxt_s != ST_IDLE);
         done        <= (state_nxt_s == ST_FINISH);
      end
   end

endmodule

// File: tb/tb_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_layer_sequencer
//
// Directed vector table, scenario runs with a distributor responder, and a
// randomized phase, all checked against a pass-number based reference model.
// -----------------------------------------------------------------------------
module tb_layer_sequencer;

   localparam int NL = 4;
   localparam int TO = 16;

   logic          l_clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic [NL-1:0] act_mask;
   logic [3:0]    p_count;
   logic          dis_all_done;
   logic          dis_en;
   logic [3:0]    layer_index;
   logic [3:0]    p_index;
   logic          need_act;
   logic          busy;
   logic          done;
   logic          timeout_err;

   layer_sequencer #(.NUM_LAYERS(NL), .TIMEOUT(TO), .TO_W(5)) dut (
      .l_clk        (l_clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .act_mask     (act_mask),
      .p_count      (p_count),
      .dis_all_done (dis_all_done),
      .dis_en       (dis_en),
      .layer_index  (layer_index),
      .p_index      (p_index),
      .need_act     (need_act),
      .busy         (busy),
      .done         (done),
      .timeout_err  (timeout_err)
   );

   always #5 l_clk = ~l_clk;

   int vectors    = 0;
   int miscompares = 0;

   // ---------------- reference model (pass-number based) ----------------
   int         m_mode;   // 0 idle, 1 issuing, 2 waiting, 3 finishing
   int         m_pass;   // pass number within the run, 0..NL*m_pc-1
   int         m_wait;
   int         m_pc;
   logic [3:0] m_mask;
   logic       m_terr;

   function automatic logic [12:0] pack(input logic de, input logic b, input logic dn,
                                        input logic te, input logic na,
                                        input logic [3:0] l, input logic [3:0] p);
      return {de, b, dn, te, na, l, p};
   endfunction

   function automatic logic [12:0] dut_vec();
      return pack(dis_en, busy, done, timeout_err, need_act, layer_index, p_index);
   endfunction

   function automatic logic [12:0] model_vec();
      logic [3:0] mm;
      if (m_mode == 0) begin
         return pack(1'b0, 1'b0, 1'b0, m_terr, 1'b0, 4'd0, 4'd0);
      end
      mm = m_mask;
      return pack(m_mode == 1, 1'b1, m_mode == 3, m_terr, mm[m_pass / m_pc],
                  4'(m_pass / m_pc + 1), 4'(m_pass % m_pc));
   endfunction

   task automatic model_reset();
      m_mode = 0; m_pass = 0; m_wait = 0; m_pc = 1; m_mask = 4'd0; m_terr = 1'b0;
   endtask

   task automatic model_step(input logic s, input logic a, input logic d,
                             input logic [3:0] m, input logic [3:0] pc);
      if (a) begin
         m_mode = 0;
      end else if (m_mode == 0) begin
         if (s) begin
            m_mask = m;
            m_pc   = (pc == 4'd0) ? 1 : int'(pc);
            m_terr = 1'b0;
            m_pass = 0;
            m_mode = 1;
         end
      end else if (m_mode == 1) begin
         m_mode = 2;
         m_wait = 0;
      end else if (m_mode == 2) begin
         if (d) begin
            if (m_pass + 1 < NL * m_pc) begin
               m_pass++;
               m_mode = 1;
            end else begin
               m_mode = 3;
            end
         end else if (m_wait == TO - 1) begin
            m_terr = 1'b1;
            m_mode = 0;
         end else begin
            m_wait++;
         end
      end else begin
         m_mode = 0;
      end
   endtask

   // ---------------- check helpers ----------------
   task automatic check_vec(input string name, input logic [12:0] got, input logic [12:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s t=%0t got {en,busy,done,terr,need,l,p}=%b want %b", name, $time, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s got %0d want %0d", name, got, exp);
      end
   endtask

   // One clock: drive inputs, step the model on the edge, sample #1 later.
   task automatic tick(input logic s, input logic a, input logic d,
                       input logic [3:0] m, input logic [3:0] pc, input logic chk);
      start = s; abort = a; dis_all_done = d; act_mask = m; p_count = pc;
      @(posedge l_clk);
      model_step(s, a, d, m, pc);
      #1;
      if (chk) check_vec("model", dut_vec(), model_vec());
   endtask

   // ---------------- scenario runner with distributor responder ----------------
   int         pulses, dones, cyc, fall_cyc, last_done_cyc, first_issue_cyc;
   logic [7:0] log_q[$];

   task automatic run(input logic [3:0] mask, input logic [3:0] pc, input int lat,
                      input int abort_layer, input logic busy_start);
      int   cnt;
      logic s, a, d;
      bit   ab_done;
      pulses = 0; dones = 0; log_q.delete(); cnt = -1;
      fall_cyc = -1; last_done_cyc = -1; first_issue_cyc = -1; ab_done = 0;
      tick(1'b1, 1'b0, 1'b0, mask, pc, 1'b1);
      cyc = 1;
      for (int guard = 0; guard < 2000; guard++) begin
         if (dis_en) begin
            pulses++;
            log_q.push_back({layer_index, p_index});
            if (first_issue_cyc < 0) first_issue_cyc = cyc;
         end
         if (done) dones++;
         if (!busy) begin
            fall_cyc = cyc;
            break;
         end
         if (dis_en) cnt = 0;
         else if (cnt >= 0) cnt++;
         d = (lat > 0 && cnt == lat);
         if (d) begin
            cnt = -1;
            last_done_cyc = cyc;
         end
         a = (abort_layer > 0 && !ab_done && !dis_en && layer_index == 4'(abort_layer));
         if (a) begin
            ab_done = 1;
            d = 1'b0;
         end
         s = busy_start;
         tick(s, a, d, mask, pc, 1'b1);
         cyc++;
      end
      if (fall_cyc < 0) begin
         vectors++;
         miscompares++;
         $display("FAIL run_bound busy still %b after 2000 cycles, want 0", busy);
      end
      // quiet tail: nothing may be issued once the run has ended
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b0, 1'b0, mask, pc, 1'b1);
         if (dis_en) pulses++;
         if (done) dones++;
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        s;
      logic        a;
      logic        d;
      logic [3:0]  m;
      logic [3:0]  pc;
      logic [12:0] exp;
   } vec_t;

   vec_t tbl[18];

   initial begin
      int idx;
      logic [7:0] want;

      // mask 0110 latched; running entries drive 1001 to prove the latch
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'b0110, 4'd1, pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0)};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 4'b1001, 4'd3, pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0)};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'b1001, 4'd3, pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd0)};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'b1001, 4'd3, pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd0)};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'b1001, 4'd3, pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0)};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 4'b1001, 4'd3, pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0)};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'b1001, 4'd3, pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd0)};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'b1001, 4'd3, pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd0)};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 4'b1001, 4'd3, pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 4'd0)};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'b1001, 4'd3, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0)};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 4'b1111, 4'd1, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0)};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 4'b1111, 4'd0, pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0)};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 4'b1111, 4'd0, pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0)};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 4'b1111, 4'd0, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0)};
      tbl[14] = '{1'b1, 1'b0, 1'b0, 4'b0001, 4'd2, pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0)};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 4'b0001, 4'd2, pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0)};
      tbl[16] = '{1'b0, 1'b0, 1'b1, 4'b0001, 4'd2, pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1)};
      tbl[17] = '{1'b0, 1'b1, 1'b0, 4'b0001, 4'd2, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0)};

      // ---------------- reset state ----------------
      rst = 1'b1; start = 1'b0; abort = 1'b0; dis_all_done = 1'b0;
      act_mask = 4'd0; p_count = 4'd0;
      model_reset();
      repeat (2) @(posedge l_clk);
      #1;
      check_vec("reset_state", dut_vec(), 13'd0);
      rst = 1'b0;
      tick(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1);

      // ---------------- table ----------------
      for (int i = 0; i < 18; i++) begin
         tick(tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].m, tbl[i].pc, 1'b0);
         check_vec($sformatf("table[%0d]", i), dut_vec(), tbl[i].exp);
      end

      // ---------------- asynchronous reset mid-WAIT ----------------
      tick(1'b1, 1'b0, 1'b0, 4'b1111, 4'd1, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 4'b1111, 4'd1, 1'b1);
      #2 rst = 1'b1;
      #1 check_vec("reset_async", dut_vec(), 13'd0);
      #2 rst = 1'b0;
      model_reset();
      tick(1'b0, 1'b0, 1'b1, 4'b1111, 4'd1, 1'b1);
      check_int("reset_idle_busy", int'(busy), 0);

      // ---------------- nominal run ----------------
      run(4'b1010, 4'd2, 3, 0, 1'b0);
      check_int("nominal_pulses", pulses, 8);
      check_int("nominal_done", dones, 1);
      check_int("nominal_busy_fall", fall_cyc - last_done_cyc, 2);
      idx = 0;
      for (int l = 1; l <= NL; l++) begin
         for (int p = 0; p < 2; p++) begin
            want = {4'(l), 4'(p)};
            if (idx < log_q.size()) check_int("nominal_order", int'(log_q[idx]), int'(want));
            idx++;
         end
      end
      check_int("nominal_log_size", log_q.size(), 8);

      // ---------------- start while busy ----------------
      run(4'b1010, 4'd2, 3, 0, 1'b1);
      check_int("busy_start_pulses", pulses, 8);
      check_int("busy_start_done", dones, 1);

      // ---------------- zero partitions ----------------
      run(4'b0011, 4'd0, 2, 0, 1'b0);
      check_int("zero_p_pulses", pulses, 4);
      for (int i = 0; i < log_q.size(); i++) begin
         check_int("zero_p_index", int'(log_q[i][3:0]), 0);
      end

      // ---------------- watchdog ----------------
      run(4'b0001, 4'd1, 100, 0, 1'b0);
      check_int("wd_pulses", pulses, 1);
      check_int("wd_done", dones, 0);
      check_int("wd_latency", fall_cyc - (first_issue_cyc + 1), TO);
      check_int("wd_flag", int'(timeout_err), 1);
      tick(1'b1, 1'b0, 1'b0, 4'b0001, 4'd1, 1'b1);
      check_int("wd_clear_on_start", int'(timeout_err), 0);
      tick(1'b0, 1'b1, 1'b0, 4'b0001, 4'd1, 1'b1);

      // ---------------- done exactly at the deadline ----------------
      run(4'b0101, 4'd1, TO, 0, 1'b0);
      check_int("deadline_pulses", pulses, 4);
      check_int("deadline_done", dones, 1);
      check_int("deadline_flag", int'(timeout_err), 0);
      run(4'b0101, 4'd1, TO + 1, 0, 1'b0);
      check_int("past_deadline_flag", int'(timeout_err), 1);
      check_int("past_deadline_done", dones, 0);

      // ---------------- abort during layer 2 ----------------
      run(4'b1111, 4'd1, 5, 2, 1'b0);
      check_int("abort_pulses", pulses, 2);
      check_int("abort_done", dones, 0);
      check_int("abort_flag", int'(timeout_err), 0);

      // ---------------- randomized phase ----------------
      for (int i = 0; i < 3000; i++) begin
         logic s, a, d;
         s = ($urandom_range(3) == 0);
         a = ($urandom_range(39) == 0);
         if ((i / 500) % 2 == 0) d = ($urandom_range(2) == 0);
         else d = ($urandom_range(19) == 0);
         tick(s, a, d, 4'($urandom_range(15)), 4'($urandom_range(3)), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
